// File: rtl/aes_round_ctrl.sv
// Iterative AES round engine: one round per clock over a 128-bit state,
// round keys fetched by index from an external combinational key store.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_decrypt,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned BW = 128;
  localparam int unsigned RW = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [BW-1:0]   st_q, st_d;
  logic [BW-1:0]   out_data_q, out_data_d;
  logic [RW-1:0]   round_q, round_d;
  logic            mode_q, mode_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            last_c;
  logic [BW-1:0]   fwd_res_c, inv_res_c;

  // GF(2^8) multiply with the AES reduction polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01;
    s = x;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // Byte i of the state lives at bits [127-8i -: 8]; column-major (i = row + 4*col)
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  // Circulant column mix: {2,3,1,1} forward, {14,11,13,9} inverse
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0]  a [4];
    logic [7:0]  m0, m1, m2, m3;
    logic [31:0] o;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    m0 = inv ? 8'd14 : 8'd2;
    m1 = inv ? 8'd11 : 8'd3;
    m2 = inv ? 8'd13 : 8'd1;
    m3 = inv ? 8'd9  : 8'd1;
    o  = '0;
    for (int r = 0; r < 4; r++)
      o[31-8*r -: 8] = gmul(a[r], m0) ^ gmul(a[(r+1)%4], m1) ^
                       gmul(a[(r+2)%4], m2) ^ gmul(a[(r+3)%4], m3);
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
    return o;
  endfunction

  assign last_c = (round_q == RW'(NR));

  // Forward round: SB -> SR -> MC (skipped on last) -> ARK
  always_comb begin
    fwd_res_c = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
    if (!last_c) fwd_res_c = mix_cols(fwd_res_c, 1'b0);
    fwd_res_c = fwd_res_c ^ rk_data;
  end

  // Inverse round: InvSR -> InvSB -> ARK -> InvMC (skipped on last)
  always_comb begin
    inv_res_c = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk_data;
    if (!last_c) inv_res_c = mix_cols(inv_res_c, 1'b1);
  end

  // Round-key index request, combinational towards the key store
  always_comb begin
    rk_idx = '0;
    case (fsm_q)
      IDLE:    rk_idx = in_decrypt ? RW'(NR) : '0;
      ROUND:   rk_idx = mode_q ? RW'(NR) - round_q : round_q;
      default: rk_idx = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    out_data_d  = out_data_q;
    round_d     = round_q;
    mode_d      = mode_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d       = in_data ^ rk_data;
          mode_d     = in_decrypt;
          round_d    = RW'(1);
          fsm_d      = ROUND;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ROUND: begin
        st_d    = mode_q ? inv_res_c : fwd_res_c;
        round_d = round_q + RW'(1);
        if (last_c) begin
          fsm_d       = DONE;
          out_valid_d = 1'b1;
          out_data_d  = mode_q ? inv_res_c : fwd_res_c;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d       = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with asynchronous abort to reset values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      st_q        <= '0;
      out_data_q  <= '0;
      round_q     <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      out_data_q  <= out_data_d;
      round_q     <= round_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: table-based AES reference, key store, per-cycle compare.
module tb_aes_round_ctrl;

  localparam int unsigned NR = 10;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_decrypt = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] rk_mem  [0:NR];

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_decrypt(in_decrypt), .in_data(in_data), .rk_idx(rk_idx), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  assign rk_data = (int'(rk_idx) <= int'(NR)) ? rk_mem[rk_idx] : '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] m_sub(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox_t[s[127-8*i -: 8]] : sbox_t[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] s);
    logic [7:0] b [16];
    logic [7:0] o [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++) o[row + 4*col] = b[row + 4*((col + row) % 4)];
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
    return r;
  endfunction

  // Textbook xtime form of MixColumns
  function automatic logic [127:0] m_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3, t;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      t = a0 ^ a1 ^ a2 ^ a3;
      r[127-32*c -: 32] = {a0 ^ t ^ xt(a0 ^ a1), a1 ^ t ^ xt(a1 ^ a2),
                           a2 ^ t ^ xt(a2 ^ a3), a3 ^ t ^ xt(a3 ^ a0)};
    end
    return r;
  endfunction

  // Inverses via group order: ShiftRows^4 = MixColumns^4 = identity
  function automatic logic [127:0] m_ishift(input logic [127:0] s);
    return m_shift(m_shift(m_shift(s)));
  endfunction

  function automatic logic [127:0] m_imix(input logic [127:0] s);
    return m_mix(m_mix(m_mix(s)));
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rk_mem[0];
    for (int r = 1; r < int'(NR); r++) s = m_mix(m_shift(m_sub(s, 1'b0))) ^ rk_mem[r];
    return m_shift(m_sub(s, 1'b0)) ^ rk_mem[NR];
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] c);
    logic [127:0] s;
    s = c ^ rk_mem[NR];
    for (int r = int'(NR) - 1; r >= 1; r--) s = m_imix(m_sub(m_ishift(s), 1'b1) ^ rk_mem[r]);
    return m_sub(m_ishift(s), 1'b1) ^ rk_mem[0];
  endfunction

  // Block timeline: m_k = cycles since accept (1..NR rounds, NR+1 = result held)
  logic         m_active = 1'b0;
  int           m_k = 0;
  logic         m_dec = 1'b0;
  logic [127:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_dec    <= in_decrypt;
        m_res    <= in_decrypt ? model_dec(in_data) : model_enc(in_data);
      end
    end else if (m_k <= int'(NR)) begin
      m_k <= m_k + 1;
    end else if (out_ready) begin
      m_active <= 1'b0;
    end
  end

  // Per-cycle compare against the timeline model
  always @(negedge clk) begin
    if (!m_active) begin
      chk("idle_in_ready", 128'(in_ready), 128'd1);
      chk("idle_busy", 128'(busy), 128'd0);
      chk("idle_out_valid", 128'(out_valid), 128'd0);
      chk("idle_rk_idx", 128'(rk_idx), in_decrypt ? 128'(NR) : 128'd0);
    end else if (m_k <= int'(NR)) begin
      chk("round_in_ready", 128'(in_ready), 128'd0);
      chk("round_busy", 128'(busy), 128'd1);
      chk("round_out_valid", 128'(out_valid), 128'd0);
      chk("round_rk_idx", 128'(rk_idx), m_dec ? 128'(int'(NR) - m_k) : 128'(m_k));
    end else begin
      chk("done_in_ready", 128'(in_ready), 128'd0);
      chk("done_busy", 128'(busy), 128'd1);
      chk("done_out_valid", 128'(out_valid), 128'd1);
      chk("done_out_data", out_data, m_res);
    end
  end

  // ---------------- directed sequences ----------------
  task automatic wait_accept(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 128'(in_ready), 128'd1);
  endtask

  task automatic do_block(input logic [127:0] d, input logic dec, input int hold,
                          input logic [127:0] exp);
    int           n;
    logic [3:0]   tr [0:NR];
    logic [127:0] held;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_decrypt = dec; out_ready = (hold == 0);
    wait_accept("accept_ready");
    tr[0] = rk_idx;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d; in_decrypt = ~dec;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= int'(NR)) tr[n] = rk_idx;
    end while (!out_valid && n < 40);
    chk("latency", 128'(n), 128'(NR + 1));
    chk("result", out_data, exp);
    for (int i = 0; i <= int'(NR); i++)
      chk("rk_trace", 128'(tr[i]), dec ? 128'(int'(NR) - i) : 128'(i));
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("post_in_ready", 128'(in_ready), 128'd1);
    chk("post_out_valid", 128'(out_valid), 128'd0);
  endtask

  // in_valid held high across the first block; second block must wait for the handshake
  task automatic two_blocks(input logic [127:0] d1, input logic dec1, input logic [127:0] e1,
                            input logic [127:0] d2, input logic dec2, input logic [127:0] e2,
                            input logic toggle);
    int first, second;
    logic [127:0] r1, r2;
    first = 0; second = 0; r1 = '0; r2 = '0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d1; in_decrypt = dec1; out_ready = 1'b1;
    wait_accept("b2b_accept");
    @(posedge clk); #1;
    in_data = d2; in_decrypt = dec2;
    for (int c = 1; c <= 30; c++) begin
      if (toggle && c <= int'(NR)) in_decrypt = ~in_decrypt;
      if (c == int'(NR) + 1) in_decrypt = dec2;
      if (c == int'(NR) + 3) in_valid = 1'b0;
      @(negedge clk);
      if (out_valid && first == 0) begin
        first = c; r1 = out_data;
      end else if (out_valid && first != 0 && c > first + 1 && second == 0) begin
        second = c; r2 = out_data;
      end
      @(posedge clk); #1;
    end
    chk("b2b_first_cycle", 128'(first), 128'(NR + 1));
    chk("b2b_second_cycle", 128'(second), 128'(2 * NR + 3));
    chk("b2b_first_data", r1, e1);
    chk("b2b_second_data", r2, e2);
  endtask

  initial begin
    logic [2047:0] sbox_flat;
    logic [31:0]   w [0:4*(NR+1)-1];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [127:0]  rnd;

    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_flat[2047-8*i -: 8];
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);

    // AES-128 key expansion for the key store
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4 * int'(NR + 1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= int'(NR); r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    // Model pinned to published values
    chk("model_rk10", rk_mem[NR], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_enc", model_enc(PT), CT);
    chk("model_dec", model_dec(CT), PT);

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // FIPS-197 C.1 encrypt, then decrypt with 5 cycles of backpressure
    do_block(PT, 1'b0, 0, CT);
    do_block(CT, 1'b1, 5, PT);

    // Asynchronous abort in round 5
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0; out_ready = 1'b1;
    wait_accept("abort_accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_out_data", out_data, 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_block(PT, 1'b0, 0, CT);

    // Busy rejection with in_decrypt toggling, then plain back-to-back
    two_blocks(PT, 1'b0, CT, CT, 1'b1, PT, 1'b1);
    two_blocks(PT, 1'b0, CT, CT, 1'b1, PT, 1'b0);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    two_blocks(rnd, 1'b0, model_enc(rnd), model_enc(rnd), 1'b1, rnd, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
